// File: rtl/qsin_nco_iq.sv
// Quadrature NCO around an external two-port quarter-sine LUT: phase accumulation and
// quadrant folding on the address side, mirror/negate reconstruction on the data side.
module qsin_nco_iq #(
  parameter int PW    = 32,
  parameter int ABITS = 10,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [PW-1:0]    freq_word,
  input  logic [PW-1:0]    phase_off,
  output logic [ABITS-1:0] lut_addr1,
  output logic [ABITS-1:0] lut_addr2,
  input  logic [DW-1:0]    lut_data1,
  input  logic [DW-1:0]    lut_data2,
  output logic [DW-1:0]    sin_out,
  output logic [DW-1:0]    cos_out,
  output logic             out_valid
);

  localparam int LOW = PW - 2 - ABITS;

  logic [PW-1:0]    acc_reg;
  logic [1:0]       quad;
  logic [ABITS-1:0] idx;
  logic             launch;
  logic             v1_reg;
  logic             v2_reg;
  logic             valid_reg;

  // Sub-index phase bits only matter for carries into the sum.
  generate
    if (LOW > 0) begin : g_low
      logic [LOW-1:0] phase_unused;
      assign {quad, idx, phase_unused} = acc_reg + phase_off;
    end else begin : g_nolow
      assign {quad, idx} = acc_reg + phase_off;
    end
  endgenerate

  assign launch = en & ~sync_clr;

  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + freq_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      v1_reg    <= launch;
      v2_reg    <= v1_reg;
      valid_reg <= v2_reg;
    end
  end

  // Channel 0 is sine, channel 1 is cosine; cosine is sine one quadrant ahead.
  // Odd quadrants read the table mirrored, the upper half-turn is negated.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [1:0]       quad_ch;
      logic [ABITS-1:0] addr_reg;
      logic             neg1_reg;
      logic             neg2_reg;
      logic [DW-1:0]    data_ch;
      logic [DW-1:0]    out_reg;

      assign quad_ch = quad + 2'(gi);
      assign data_ch = (gi == 0) ? lut_data1 : lut_data2;

      always_ff @(posedge clk) begin
        if (rst) begin
          addr_reg <= '0;
          neg1_reg <= 1'b0;
          neg2_reg <= 1'b0;
          out_reg  <= '0;
        end else begin
          if (launch) begin
            addr_reg <= quad_ch[0] ? ~idx : idx;
            neg1_reg <= quad_ch[1];
          end
          neg2_reg <= neg1_reg;
          if (v2_reg) begin
            out_reg <= neg2_reg ? DW'(-data_ch) : data_ch;
          end
        end
      end
    end
  endgenerate

  assign lut_addr1 = g_ch[0].addr_reg;
  assign lut_addr2 = g_ch[1].addr_reg;
  assign sin_out   = g_ch[0].out_reg;
  assign cos_out   = g_ch[1].out_reg;
  assign out_valid = valid_reg;

endmodule

// File: doc/qsin_nco_iq.md
Name: qsin_nco_iq

Overview:
- Quadrature NCO front/back end for the two-port quarter-sine LUT used in the beacon I/Q downconverter.
- Holds a phase accumulator and folds phase into quadrant and index; drives the LUT's two address ports (port 1 sine, port 2 cosine).
- Takes the LUT's registered outputs and mirrors/negates them into full-wave signed sin/cos samples with a valid tag.
- The LUT is instantiated alongside this block, not inside it.

Parameters:
- PW, 32, phase accumulator / frequency word width. Must satisfy PW ≥ ABITS+2.
- ABITS, 10, LUT address width; quarter-wave table of N = 2^ABITS entries.
- DW, 16, LUT data and sample width, two's complement. Table SCALE must be ≤ 2^(DW-1)-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance phase and launch one sample this cycle.
- sync_clr  in  1  zero the phase accumulator.
- freq_word  in  PW  phase increment per enabled cycle, unsigned.
- phase_off  in  PW  phase offset added to the launched phase, unsigned.
- lut_addr1  out  ABITS  sine address, to LUT port 1.
- lut_addr2  out  ABITS  cosine address, to LUT port 2.
- lut_data1  in  DW  LUT port 1 data, 1-cycle latency after lut_addr1.
- lut_data2  in  DW  LUT port 2 data, 1-cycle latency after lut_addr2.
- sin_out  out  DW  signed sine sample.
- cos_out  out  DW  signed cosine sample.
- out_valid  out  1  sin_out/cos_out valid, single-cycle pulse per sample.

Behaviour:
- Reset (edge with rst=1): acc, lut_addr1/2, neg flags, stage valid bits, sin_out, cos_out and out_valid all go to 0. In-flight samples are discarded.
- Phase: p = acc + phase_off, mod 2^PW.
  - q = p[PW-1:PW-2].
  - idx = p[PW-3:PW-2-ABITS].
  - ~idx means N-1-idx.
- Accumulator update, in priority order:
  - rst.
  - sync_clr: acc ← 0, no sample launched even if en=1.
  - en: acc ← acc + freq_word, mod 2^PW (wraps silently).
  - Otherwise acc holds.
- Stage 1 (edge k with launch) captures p, folded as follows:
  - Sine:
    - q=0: addr idx, positive.
    - q=1: addr ~idx, positive.
    - q=2: addr idx, negative.
    - q=3: addr ~idx, negative.
  - Cosine uses quadrant (q+1) mod 4 with the same idx:
    - q=0: ~idx, positive.
    - q=1: idx, negative.
    - q=2: ~idx, negative.
    - q=3: idx, positive.
  - Registers lut_addr1, lut_addr2, neg_s, neg_c; v1 ← 1.
- Stage 2 (edge k+1): LUT registers data; block delays neg_s/neg_c and v1 → v2.
- Stage 3 (edge k+2): sin_out ← neg_s ? -lut_data1 : lut_data1, likewise cos_out; out_valid ← v2.
  - Negation is DW-bit two's complement; no saturation needed given the SCALE bound.
- Latency: sample launched with en at edge k appears with out_valid=1 after edge k+2, i.e. 3 cycles after the en cycle. Throughput is 1 sample/cycle.
- Pipeline runs every cycle; only valid bits gate meaning. When no sample is launched, v1 ← 0 and addresses/flags may hold.
- sin_out/cos_out hold their last value while out_valid=0.
- sync_clr or en changes never disturb samples already in flight.
- freq_word and phase_off are sampled only on launch cycles; they may change every cycle.

Test Plan:
- Quarter-turn stepping: PW=32, ABITS=10, DW=16, SCALE=32767, freq_word=0x4000_0000, phase_off=0, en held → (sin,cos) sequence (0,32767), (32767,0), (0,-32767), (-32767,0), repeating.
- Latency/pulse: after rst, a single en pulse in cycle 0 → out_valid high only in cycle 3, (sin,cos)=(0,32767). With en held continuously, out_valid stays high from cycle 3.
- Offset: freq_word=0, phase_off=0x8000_0000, en held → constant (0,-32767). phase_off=0x4000_0000 → (32767,0).
- Wrap: freq_word=0x8000_0000, en held → acc alternates 0, 0x8000_0000; outputs alternate (0,32767), (0,-32767) with no glitch at overflow.
- sync_clr mid-stream: freq_word=0x4000_0000, en held, sync_clr in cycle 2 → one missing sample (out_valid low in cycle 5), then the sequence restarts at (0,32767). Samples launched in cycles 0–1 still emerge in cycles 3–4.
- Reset mid-operation: rst asserted one cycle while 3 samples are in flight → out_valid=0 and outputs 0 from the next cycle. No stale samples emerge. After release plus en, first output is (0,32767), 3 cycles later.
